// File: rtl/haar_stage_evaluator.sv
`default_nettype none
// ============================================================================
// Module   : haar_stage_evaluator
// Function : Walks one cascade stage's weak classifiers, sums the selected
//            leaves and returns a registered pass/fail verdict.
// Revision : 1.0  initial release
// ============================================================================
module haar_stage_evaluator #(
  parameter int ADDR_W = 16,
  parameter int SUM_W  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [ADDR_W-1:0]        stage_start_address,
  input  logic [ADDR_W-1:0]        no_of_weak_classifiers,
  input  logic signed [SUM_W-1:0]  stage_threshold,
  output logic [ADDR_W-1:0]        wc_addr,
  input  logic [63:0]              wc_data,
  output logic                     feat_req,
  output logic [15:0]              feat_idx,
  input  logic                     feat_valid,
  input  logic signed [15:0]       feat_value,
  output logic                     busy,
  output logic                     done,
  output logic                     stage_valid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_FEAT   = 3'd3,
    S_DECIDE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [ADDR_W-1:0]         r_base;
  logic [ADDR_W-1:0]         r_count;
  logic [ADDR_W-1:0]         r_i;
  logic signed [SUM_W-1:0]   r_thr;
  logic signed [SUM_W-1:0]   r_sum;
  logic signed [15:0]        r_node_thr;
  logic signed [15:0]        r_left;
  logic signed [15:0]        r_right;
  logic [ADDR_W-1:0]         w_i_next;
  logic signed [15:0]        w_leaf;
  logic signed [SUM_W-1:0]   w_leaf_ext;

  assign w_i_next   = r_i + 1'b1;
  assign w_leaf     = (feat_value < r_node_thr) ? r_left : r_right;
  assign w_leaf_ext = {{(SUM_W-16){w_leaf[15]}}, w_leaf};
  assign busy       = (r_state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (no_of_weak_classifiers == '0) ? S_DECIDE : S_FETCH;
        end
      end
      S_FETCH:  w_next = S_WAIT;
      S_WAIT:   w_next = S_FEAT;
      S_FEAT: begin
        if (feat_valid) begin
          w_next = (w_i_next == r_count) ? S_DECIDE : S_FETCH;
        end
      end
      S_DECIDE: w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // wc_addr is loaded on the edge entering FETCH so the BRAM samples it at the
  // end of FETCH and the record is on wc_data throughout WAIT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base      <= '0;
      r_count     <= '0;
      r_i         <= '0;
      r_thr       <= '0;
      r_sum       <= '0;
      r_node_thr  <= '0;
      r_left      <= '0;
      r_right     <= '0;
      wc_addr     <= '0;
      feat_req    <= 1'b0;
      feat_idx    <= '0;
      done        <= 1'b0;
      stage_valid <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_base      <= stage_start_address;
            r_count     <= no_of_weak_classifiers;
            r_thr       <= stage_threshold;
            r_sum       <= '0;
            r_i         <= '0;
            stage_valid <= 1'b0;
            if (no_of_weak_classifiers != '0) begin
              wc_addr <= stage_start_address;
            end
          end
        end
        S_WAIT: begin
          r_node_thr <= wc_data[63:48];
          r_left     <= wc_data[47:32];
          r_right    <= wc_data[31:16];
          feat_idx   <= wc_data[15:0];
          feat_req   <= 1'b1;
        end
        S_FEAT: begin
          if (feat_valid) begin
            feat_req <= 1'b0;
            r_sum    <= r_sum + w_leaf_ext;
            r_i      <= w_i_next;
            if (w_i_next != r_count) begin
              wc_addr <= r_base + w_i_next;
            end
          end
        end
        S_DECIDE: begin
          stage_valid <= (r_sum >= r_thr);
          done        <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/haar_stage_evaluator.md
# haar_stage_evaluator

Responder side of the stage-sequencer interface. The stage sequencer reads a stage-table word, presents the stage's first weak-classifier address and classifier count, and waits for a pass/fail verdict. This block walks that stage's weak-classifier records in the classifier BRAM and requests each feature value from the feature unit. It accumulates the selected leaf values, compares the sum against the stage threshold, and returns a registered verdict with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_W, 16: classifier BRAM address width; also the width of start address and count.
- SUM_W, 32: signed accumulator width.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  single-cycle request; sampled only in IDLE.
- stage_start_address  in  ADDR_W  address of the stage's first weak-classifier record.
- no_of_weak_classifiers  in  ADDR_W  number of records in the stage (0 allowed).
- stage_threshold  in  SUM_W  signed pass threshold.
- wc_addr  out  ADDR_W  classifier BRAM address; the BRAM has 1-cycle synchronous read latency.
- wc_data  in  64  record: [63:48] node threshold s16, [47:32] left value s16, [31:16] right value s16, [15:0] feature index.
- feat_req  out  1  feature request; held until accepted.
- feat_idx  out  16  feature index for the current request.
- feat_valid  in  1  feature unit response strobe.
- feat_value  in  16  signed feature value, valid with feat_valid.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the verdict is updated.
- stage_valid  out  1  verdict: 1 when sum >= stage_threshold; held until the next accepted start.

## Operation
- States: IDLE, FETCH, WAIT, FEAT, DECIDE, DONE.
- IDLE, start=1:
  - Latch start address, count and threshold.
  - Clear sum, index i and stage_valid.
  - If count==0, go to DECIDE; otherwise go to FETCH.
- IDLE, start=0: stay in IDLE.
- FETCH: drive wc_addr = latched start + i (ADDR_W wrap-around, modulo 2^16); go to WAIT.
- WAIT: BRAM data arrives; register the record; go to FEAT.
- FEAT:
  - feat_req=1 and feat_idx = record[15:0], held stable until feat_valid is sampled high.
  - On feat_valid:
    - if feat_value < node threshold (signed compare), add sign-extended left value to sum; otherwise add right value.
    - i += 1.
    - If i == count, go to DECIDE; otherwise go to FETCH.
  - feat_valid outside FEAT is ignored.
- DECIDE: compute sum >= stage_threshold (signed); go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - stage_valid takes the verdict on entry to DONE.
  - Then go to IDLE.
- Arithmetic: the 32-bit sum cannot overflow (at most 65535 × 32768 < 2^31), so no saturation is needed.
- start while busy=1 is ignored, not queued.
- Inputs stage_start_address, no_of_weak_classifiers and stage_threshold may change after start is accepted without effect.
- Reset mid-operation:
  - Immediately returns to IDLE.
  - busy, done, feat_req and stage_valid become 0; sum and i become 0.
  - No partial verdict is produced.

## Timing
- Reset values: busy=0, done=0, stage_valid=0, feat_req=0, feat_idx=0, wc_addr=0.
- Edge 0 accepts start. Each classifier takes 3 cycles (FETCH, WAIT, FEAT) when feat_valid is high in the first FEAT cycle. Each extra feature-unit wait cycle adds 1 cycle.
- With zero-wait feature responses, done is high in the cycle after edge 3N+1. N=0 gives done after edge 1.
- A new start may be accepted in the cycle after done, since the block is back in IDLE.
- feat_req rises on the edge entering FEAT and falls on the edge after feat_valid is sampled.
- wc_addr is registered; it is stable for the whole WAIT cycle.

## Test plan
- Single stage, N=2, start address 0x0010:
  - Records: record0 (thr 100, L 5, R -3, idx 7), record1 (thr -20, L 10, R 40, idx 2).
  - Feature values 50 and 0; stage_threshold 44.
  - Required: sum 5+40=45, stage_valid=1, done after edge 7, wc_addr sequence 0x0010, 0x0011.
- Same records, stage_threshold 46: required stage_valid=0, done pulse width exactly 1 cycle.
- N=0, stage_threshold 0 and then 1: required stage_valid=1 and then 0, done after edge 1, wc_addr and feat_req never active.
- Feature unit delays feat_valid by 3 cycles per request, N=3:
  - feat_req and feat_idx stay stable while waiting.
  - done arrives after edge 3×3+1+9=19.
  - A start pulse during busy is ignored.
- Start address 0xFFFF, N=2: required wc_addr 0xFFFF then 0x0000.
- Assert reset during FEAT of classifier 1 of 3: required immediate busy=0, feat_req=0, stage_valid=0 and no done pulse; a following start runs a full evaluation correctly.
